// File: rtl/i2c_target.sv
// I2C target with a NUM_REGS x 8 register file, auto-incrementing pointer and a host-side port.
// SCL/SDA are synchronised into clk; all bus activity is decoded from edges of the synced lines.
module i2c_target #(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned NUM_REGS    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        sda_o,
    input  logic [$clog2(NUM_REGS)-1:0] host_addr,
    input  logic                        host_we,
    input  logic [7:0]                  host_wdata,
    output logic [7:0]                  host_rdata,
    output logic                        busy,
    output logic                        wr_pulse
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck
    } state_e;

    logic          scl_s1_q, scl_s2_q, scl_prev_q;
    logic          sda_s1_q, sda_s2_q, sda_prev_q;
    logic          scl_rise, scl_fall, start_det, stop_det, rx_state;
    state_e        state_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [AW-1:0] ptr_q;
    logic          ack_q;
    logic [7:0]    regs_q [NUM_REGS];

    // Synchronisers reset to the idle-bus level so reset release never looks like a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_s1_q   <= scl_i;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda_i;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    assign scl_rise   = scl_s2_q & ~scl_prev_q;
    assign scl_fall   = ~scl_s2_q & scl_prev_q;
    assign start_det  = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    assign stop_det   = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
    assign rx_state   = (state_q == StAddr) || (state_q == StPtr) || (state_q == StWdata);
    assign host_rdata = regs_q[host_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sda_o     <= 1'b1;
            busy      <= 1'b0;
            wr_pulse  <= 1'b0;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= '0;
            ack_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            wr_pulse <= 1'b0;
            // Host write first so a same-cycle I2C write to the same register overrides it.
            if (host_we) begin
                regs_q[host_addr] <= host_wdata;
            end

            if (stop_det) begin
                state_q <= StIdle;
                sda_o   <= 1'b1;
                busy    <= 1'b0;
            end else if (start_det) begin
                state_q   <= StAddr;
                bit_cnt_q <= 4'd0;
                sda_o     <= 1'b1;
            end else begin
                if (rx_state && scl_rise && bit_cnt_q != 4'd8) begin
                    shift_q   <= {shift_q[6:0], sda_s2_q};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end

                unique case (state_q)
                    StAddr: begin
                        if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= 4'd0;
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                sda_o   <= 1'b0;
                                busy    <= 1'b1;
                                state_q <= StAddrAck;
                            end else begin
                                sda_o   <= 1'b1;
                                busy    <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            if (!shift_q[0]) begin
                                sda_o     <= 1'b1;
                                bit_cnt_q <= 4'd0;
                                state_q   <= StPtr;
                            end else begin
                                // Byte is captured here, so later host writes cannot disturb it.
                                shift_q   <= regs_q[ptr_q];
                                sda_o     <= regs_q[ptr_q][7];
                                ptr_q     <= ptr_q + AW'(1);
                                bit_cnt_q <= 4'd1;
                                state_q   <= StRdata;
                            end
                        end
                    end
                    StPtr: begin
                        if (scl_fall && bit_cnt_q == 4'd8) begin
                            ptr_q     <= shift_q[AW-1:0];
                            sda_o     <= 1'b0;
                            bit_cnt_q <= 4'd0;
                            state_q   <= StPtrAck;
                        end
                    end
                    StPtrAck, StWdataAck: begin
                        if (scl_fall) begin
                            sda_o     <= 1'b1;
                            bit_cnt_q <= 4'd0;
                            state_q   <= StWdata;
                        end
                    end
                    StWdata: begin
                        if (scl_fall && bit_cnt_q == 4'd8) begin
                            regs_q[ptr_q] <= shift_q;
                            wr_pulse      <= 1'b1;
                            ptr_q         <= ptr_q + AW'(1);
                            sda_o         <= 1'b0;
                            bit_cnt_q     <= 4'd0;
                            state_q       <= StWdataAck;
                        end
                    end
                    StRdata: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_o   <= 1'b1;
                                ack_q   <= 1'b0;
                                state_q <= StRdataAck;
                            end else begin
                                sda_o     <= shift_q[6];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    StRdataAck: begin
                        if (scl_rise) begin
                            if (sda_s2_q) begin
                                sda_o   <= 1'b1;
                                busy    <= 1'b0;
                                state_q <= StIdle;
                            end else begin
                                ack_q <= 1'b1;
                            end
                        end else if (scl_fall && ack_q) begin
                            shift_q   <= regs_q[ptr_q];
                            sda_o     <= regs_q[ptr_q][7];
                            ptr_q     <= ptr_q + AW'(1);
                            bit_cnt_q <= 4'd1;
                            state_q   <= StRdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level controller driver, register-file reference model and a
// queue-based scoreboard compared by an independent monitor process.
module tb_i2c_target;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned AW       = $clog2(NUM_REGS);
    localparam logic [6:0]  TADDR    = 7'h50;
    localparam int          Q        = 40;

    typedef struct {
        string name;
        int    val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scl = 1'b1;
    logic          sda_m = 1'b1;
    logic          sda_o;
    logic          sda_bus;
    logic [AW-1:0] host_addr = '0;
    logic          host_we = 1'b0;
    logic [7:0]    host_wdata = 8'h00;
    logic [7:0]    host_rdata;
    logic          busy;
    logic          wr_pulse;

    exp_t       exp_q[$];
    int         obs_q[$];
    exp_t       mon_e;
    int         mon_o;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       done_req = 1'b0;
    logic       done_ack = 1'b0;
    int         wr_cnt = 0;
    int         sda_low_cnt = 0;
    int         busy_cnt = 0;

    logic [7:0] mreg [NUM_REGS];
    int         mptr;
    int         exp_wr;
    logic [7:0] dq[$];
    int         w0, l0, b0;
    time        t0;
    logic       s_tb;

    assign sda_bus = sda_m & sda_o;

    i2c_target #(.TARGET_ADDR(TADDR), .NUM_REGS(NUM_REGS)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_o     (sda_o),
        .host_addr (host_addr),
        .host_we   (host_we),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .busy      (busy),
        .wr_pulse  (wr_pulse)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1);
    end

    initial forever begin
        @(negedge clk);
        if (wr_pulse) wr_cnt++;
        if (!sda_o) sda_low_cnt++;
        if (busy) busy_cnt++;
    end

    // Scoreboard monitor: pairs each observation with the oldest pending expectation.
    initial forever begin
        @(negedge clk);
        while (obs_q.size() > 0) begin
            mon_o = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL orphan: got 0x%0h, required no observation", mon_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.val != mon_o) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h, required 0x%0h", mon_e.name, mon_o, mon_e.val);
                end
            end
        end
        if (done_req && !done_ack) begin
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: got %0d unobserved expectations, required 0",
                         exp_q.size());
            end
            done_ack = 1'b1;
        end
    end

    task automatic expect_val(input string name, input int v);
        exp_t e;
        e.name = name;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int v);
        obs_q.push_back(v);
    endtask

    task automatic bit_x(input logic b, output logic s);
        sda_m = b;
        #(Q) scl = 1'b1;
        #(Q) s = sda_bus;
        #(Q) scl = 1'b0;
        #(Q);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        #(Q) scl = 1'b1;
        #(Q) sda_m = 1'b0;
        #(Q) scl = 1'b0;
        #(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        #(Q) scl = 1'b1;
        #(Q) sda_m = 1'b1;
        #(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input string name, input int exp_ack);
        logic s;
        expect_val(name, exp_ack);
        for (int i = 7; i >= 0; i--) bit_x(b[i], s);
        bit_x(1'b1, s);
        observe(int'(s));
    endtask

    task automatic recv_byte(input int exp_b, input logic nack);
        logic       s;
        logic [7:0] r;
        expect_val("rd_byte", exp_b);
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, s);
            r[i] = s;
        end
        bit_x(nack, s);
        observe(int'(r));
    endtask

    // Reference model: an addressed write sets ptr = byte mod depth, then stores bytes at ptr++.
    task automatic i2c_write(input logic [6:0] a, input logic [7:0] p, input logic [7:0] d[$]);
        bit match;
        match = (a == TADDR);
        bus_start();
        send_byte({a, 1'b0}, "addr_ack", match ? 0 : 1);
        if (match) begin
            expect_val("busy_mid", 1);
            observe(int'(busy));
        end
        send_byte(p, "ptr_ack", match ? 0 : 1);
        if (match) mptr = int'(p) % NUM_REGS;
        foreach (d[i]) begin
            send_byte(d[i], "data_ack", match ? 0 : 1);
            if (match) begin
                mreg[mptr] = d[i];
                mptr = (mptr + 1) % NUM_REGS;
                exp_wr++;
            end
        end
        bus_stop();
    endtask

    task automatic i2c_read(input int n, input bit set_ptr, input logic [7:0] p);
        bus_start();
        if (set_ptr) begin
            send_byte({TADDR, 1'b0}, "addr_ack", 0);
            send_byte(p, "ptr_ack", 0);
            mptr = int'(p) % NUM_REGS;
            bus_start();
        end
        send_byte({TADDR, 1'b1}, "addr_ack", 0);
        for (int i = 0; i < n; i++) begin
            recv_byte(int'(mreg[mptr]), i == n - 1);
            mptr = (mptr + 1) % NUM_REGS;
        end
        bus_stop();
    endtask

    task automatic host_write(input int a, input logic [7:0] d);
        host_addr  = AW'(a);
        host_wdata = d;
        host_we    = 1'b1;
        #10 host_we = 1'b0;
        mreg[a] = d;
    endtask

    task automatic check_regs();
        for (int i = 0; i < NUM_REGS; i++) begin
            host_addr = AW'(i);
            #10;
            expect_val($sformatf("reg[%0d]", i), int'(mreg[i]));
            observe(int'(host_rdata));
        end
    endtask

    task automatic expect_idle();
        expect_val("idle_sda", 1);
        observe(int'(sda_o));
        expect_val("idle_busy", 0);
        observe(int'(busy));
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) mreg[i] = 8'h00;
        mptr   = 0;
        exp_wr = 0;

        // Reset state, checked while reset is held and after release.
        @(negedge clk);
        expect_val("rst_sda", 1);
        observe(int'(sda_o));
        expect_val("rst_busy", 0);
        observe(int'(busy));
        expect_val("rst_wr_pulse", 0);
        observe(int'(wr_pulse));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #(Q);
        check_regs();

        // Two-byte write from pointer 3.
        w0 = wr_cnt;
        dq = '{8'h11, 8'h22};
        i2c_write(TADDR, 8'h03, dq);
        #(Q);
        expect_val("wr_pulses_a", 2);
        observe(wr_cnt - w0);
        expect_idle();
        check_regs();

        // Pointer wrap on read, then a pointer-less read proves the pointer persisted.
        host_write(15, 8'hA5);
        host_write(0, 8'h5A);
        host_write(1, 8'hC3);
        host_write(2, 8'h3C);
        i2c_read(3, 1'b1, 8'h0F);
        #(Q);
        expect_idle();
        i2c_read(1, 1'b0, 8'h00);

        // Foreign address: bus must be left alone.
        w0 = wr_cnt;
        l0 = sda_low_cnt;
        b0 = busy_cnt;
        dq = '{8'hEE, 8'h44};
        i2c_write(7'h51, 8'h06, dq);
        expect_val("nomatch_sda_low", 0);
        observe(sda_low_cnt - l0);
        expect_val("nomatch_busy", 0);
        observe(busy_cnt - b0);
        expect_val("nomatch_wr", 0);
        observe(wr_cnt - w0);
        check_regs();

        // STOP in the middle of a data byte.
        w0 = wr_cnt;
        bus_start();
        send_byte({TADDR, 1'b0}, "addr_ack", 0);
        send_byte(8'h06, "ptr_ack", 0);
        mptr = 6;
        bit_x(1'b1, s_tb);
        bit_x(1'b0, s_tb);
        bit_x(1'b1, s_tb);
        bit_x(1'b0, s_tb);
        bus_stop();
        #(Q);
        expect_val("partial_wr", 0);
        observe(wr_cnt - w0);
        expect_idle();
        check_regs();

        // Host write to reg[5] in the very clk the I2C write of 0x99 lands.
        bus_start();
        send_byte({TADDR, 1'b0}, "addr_ack", 0);
        send_byte(8'h05, "ptr_ack", 0);
        for (int i = 7; i >= 1; i--) begin
            dq = '{8'h99};
            bit_x(dq[0][i], s_tb);
        end
        sda_m = 1'b1;
        #(Q) scl = 1'b1;
        #(Q);
        #(Q) scl = 1'b0;
        t0 = $time;
        repeat (2) @(posedge clk);
        #1;
        host_addr  = AW'(5);
        host_wdata = 8'h77;
        host_we    = 1'b1;
        @(posedge clk);
        #1 host_we = 1'b0;
        #(t0 + Q - $time);
        expect_val("collide_ack", 0);
        bit_x(1'b1, s_tb);
        observe(int'(s_tb));
        mreg[5] = 8'h99;
        mptr    = 6;
        exp_wr++;
        bus_stop();
        check_regs();

        // Reset while the target is driving the address ACK.
        bus_start();
        for (int i = 7; i >= 0; i--) bit_x(i == 7 || i == 5, s_tb);
        expect_val("ack_driven", 0);
        observe(int'(sda_o));
        #3 rst = 1'b1;
        #1;
        expect_val("rst_async_sda", 1);
        observe(int'(sda_o));
        sda_m = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) mreg[i] = 8'h00;
        mptr = 0;
        scl = 1'b1;
        #(Q) scl = 1'b0;
        #(Q);
        bus_stop();
        expect_idle();
        dq = '{8'h42};
        i2c_write(TADDR, 8'h09, dq);
        check_regs();

        // Randomised traffic against the model.
        for (int n = 0; n < 16; n++) begin
            int        kind;
            int        len;
            logic [6:0] a;
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 4);
            dq.delete();
            for (int i = 0; i < len; i++) dq.push_back(8'($urandom));
            unique case (kind)
                0: i2c_write(TADDR, 8'($urandom), dq);
                1: i2c_read(len, 1'($urandom), 8'($urandom));
                2: begin
                    a = 7'($urandom);
                    if (a == TADDR) a = 7'h51;
                    i2c_write(a, 8'($urandom), dq);
                end
                default: host_write($urandom_range(0, NUM_REGS - 1), 8'($urandom));
            endcase
            #(Q);
        end
        expect_idle();
        check_regs();
        expect_val("wr_total", exp_wr);
        observe(wr_cnt);

        done_req = 1'b1;
        for (int i = 0; i < 200 && !done_ack; i++) @(negedge clk);
        if (!done_ack) begin
            $display("FAIL scoreboard_drain: monitor not finished, required finished");
            $fatal(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The block SHALL have parameter TARGET_ADDR, default 7'h50, giving the 7-bit I2C address the block responds to.
REQ-002 The block SHALL have parameter NUM_REGS, default 16, giving the register-file depth; it is a power of 2, from 2 to 256.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port scl_i, input, 1 bit: SCL line level, asynchronous to clk.
REQ-006 The block SHALL have port sda_i, input, 1 bit: SDA line level, asynchronous to clk.
REQ-007 The block SHALL have port sda_o, output, 1 bit: SDA open-drain drive; 1 releases the line, 0 pulls it low.
REQ-008 The block SHALL have port host_addr, input, $clog2(NUM_REGS) bits: host-side register index.
REQ-009 The block SHALL have port host_we, input, 1 bit: host write strobe.
REQ-010 The block SHALL have port host_wdata, input, 8 bits: host write data.
REQ-011 The block SHALL have port host_rdata, output, 8 bits: combinational read of reg[host_addr].
REQ-012 The block SHALL have port busy, output, 1 bit: high between an address match and the next STOP, or until the block returns to IDLE.
REQ-013 The block SHALL have port wr_pulse, output, 1 bit: one-clk pulse each time an I2C data byte is written to the register file.

Function
REQ-014 scl_i and sda_i SHALL each pass through a 2-flop synchronizer; all detection SHALL use the synchronized values and their previous-cycle copies.
REQ-015 Events SHALL be detected as follows:
- START: synchronized SDA 1->0 while synchronized SCL is 1.
- STOP: synchronized SDA 0->1 while synchronized SCL is 1.
- SCL rise and SCL fall: edges of synchronized SCL.
REQ-016 Input bits SHALL be sampled on SCL rise, MSB first; sda_o SHALL change only on the clk cycle that detects SCL fall.
REQ-017 The FSM SHALL have states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-018 START SHALL move the FSM from any state to ADDR, clear the bit counter, and release sda_o; this includes repeated START.
REQ-019 STOP SHALL move the FSM from any state to IDLE, release sda_o, and deassert busy.
REQ-020 ADDR SHALL shift in 8 bits; on the 8th SCL fall:
- address matches TARGET_ADDR: drive sda_o=0 (ACK) and enter ADDR_ACK.
- mismatch: enter IDLE with sda_o=1, ignoring the bus until the next START.
REQ-021 On the SCL fall that ends ADDR_ACK:
- R/W=0: release sda_o and enter PTR.
- R/W=1: load shift register with reg[ptr], drive its MSB, increment ptr, and enter RDATA.
REQ-022 PTR SHALL shift in 8 bits, then:
- set ptr = byte mod NUM_REGS.
- ACK as in REQ-020 and enter PTR_ACK.
- on the next SCL fall, release sda_o and enter WDATA.
REQ-023 WDATA SHALL shift in 8 bits; on the 8th SCL fall it SHALL:
- write reg[ptr] and pulse wr_pulse for one clk.
- increment ptr.
- ACK and enter WDATA_ACK, which returns to WDATA on the next SCL fall.
REQ-024 RDATA SHALL drive the next bit on each SCL fall; after 8 bits it SHALL release sda_o and enter RDATA_ACK.
REQ-025 RDATA_ACK SHALL sample the controller's response on SCL rise:
- ACK (0): on the next SCL fall, load reg[ptr], drive its MSB, increment ptr, and enter RDATA.
- NACK (1): enter IDLE with sda_o released.
REQ-026 ptr SHALL increment modulo NUM_REGS, wrapping from NUM_REGS-1 to 0.
REQ-027 ptr SHALL persist across transactions; it is not reset by START or STOP.
REQ-028 If host_we and an I2C write target the same register in the same clk, the I2C write SHALL win.
REQ-029 A host write to a register whose byte is already in the read shift register SHALL NOT alter the byte being transmitted.
REQ-030 Latency from the SCL falling edge at scl_i to the sda_o change SHALL be 3 clk cycles (2 sync + 1 register).

Reset
REQ-031 While rst=1, the block SHALL hold:
- FSM in IDLE, sda_o=1, busy=0, wr_pulse=0.
- ptr=0, bit counter=0.
- all registers = 8'h00.
- both synchronizers = 1 (bus idle).
REQ-032 Reset asserted mid-transaction SHALL release SDA within the same cycle (async); after reset, the block SHALL ignore the bus until a fresh START.

Verification
REQ-033 Scenario: write 0xA0,0x03,0x11,0x22 with STOP -> 4 ACKs; reg[3]=0x11, reg[4]=0x22; two wr_pulses; busy low after STOP.
REQ-034 Scenario: write 0xA0,0x0F; repeated START; 0xA1; read 3 bytes ACK,ACK,NACK -> bytes reg[15],reg[0],reg[1]; ptr=2; FSM in IDLE.
REQ-035 Scenario: address 0xA2 (0x51) -> SDA never pulled low, busy stays 0, no register changes.
REQ-036 Scenario: STOP after 4 bits of a WDATA byte -> no write, FSM in IDLE, sda_o=1.
REQ-037 Scenario: host_we to reg[5]=0x77 in the same clk the I2C write of 0x99 to reg[5] lands -> reg[5]=0x99.
REQ-038 Scenario: rst pulse while the block drives an ACK -> sda_o=1 immediately; the next addressed write succeeds.
